// File: rtl/serial_addsub_word.sv
// serial_addsub_word
//   Digit-serial adder/subtractor, LSB-first, with word framing. Each clock
//   consumes DIGIT bits of a and b; a word takes N = WIDTH/DIGIT clocks,
//   with the start edge consuming digit 0. Sum digits stream out one cycle
//   after they are consumed. The assembled word, carry out and signed
//   overflow load on the edge consuming the last digit, and done pulses in
//   the following cycle.
//
//   Optional build macro: SERIAL_ADDSUB_SAT_EN -- when defined, an
//   overflowing result loads the signed saturation value into sum.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   start    begin a word (accepted in IDLE or DONE only)
//   sub      0 = a+b, 1 = a-b, latched at an accepted start
//   cin      carry-in (add) / borrow-in (sub), applied at start
//   a_dig    operand A digit, LSB-first
//   b_dig    operand B digit, LSB-first
//   s_dig    registered sum digit
//   s_valid  s_dig valid this cycle
//   busy     high while in RUN
//   done     one-cycle pulse: sum/cout/ovf just updated
//   sum      result word, held until the next completion
//   cout     carry out of MSB (sub: 1 = no borrow)
//   ovf      signed overflow of the completed word
module serial_addsub_word #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    output logic [DIGIT-1:0] s_dig,
    output logic             s_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            carry;
    logic            sub_r;

    logic            accept;
    logic            consume;
    logic            last;
    logic            cur_sub;
    logic            cur_carry;
    logic [DIGIT-1:0] b_eff;
    logic [DIGIT:0]  digit_sum;
    logic [DIGIT-1:0] s_p0;
    logic            c_p0;
    logic            ovf_p0;
    logic [WIDTH-1:0] word_p0;

`ifdef SERIAL_ADDSUB_SAT_EN
    // Overflow only happens when both effective operands share a sign, so
    // the sign of a tells which rail the true result lies beyond.
    function automatic logic [WIDTH-1:0] sat_word(input logic neg);
        sat_word = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    // Stage p0: digit arithmetic on the consuming edge
    always_comb begin
        accept    = start && (state != RUN);
        consume   = accept || (state == RUN);
        last      = accept ? (N == 1) : ((state == RUN) && (count == CW'(N - 1)));
        // The start edge uses the live sub/cin; later digits use the latched
        // mode and the running carry.
        cur_sub   = accept ? sub : sub_r;
        cur_carry = accept ? (sub ^ cin) : carry;
        b_eff     = b_dig ^ {DIGIT{cur_sub}};
        digit_sum = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cur_carry};
        s_p0      = digit_sum[DIGIT-1:0];
        c_p0      = digit_sum[DIGIT];
        // a^b^s at the MSB recovers the carry into the MSB.
        ovf_p0    = a_dig[DIGIT-1] ^ b_eff[DIGIT-1] ^ s_p0[DIGIT-1] ^ c_p0;
    end

    // Collected digits: the newest digit enters at the top and the oldest
    // falls off the bottom, so after N digits the word is LSB-aligned.
    generate
        if (N == 1) begin : g_single
            assign word_p0 = s_p0;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] shreg_p1;
            assign word_p0 = {s_p0, shreg_p1};
            always_ff @(posedge clk) begin
                if (consume) shreg_p1 <= word_p0[WIDTH-1:DIGIT];
            end
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = (N == 1) ? DONE : RUN;
                    count_nxt = (N == 1) ? '0 : CW'(1);
                end else begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Stage p1: registered control, stream and result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            carry   <= 1'b0;
            s_dig   <= '0;
            s_valid <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            s_valid <= consume;
            done    <= last;
            if (consume) begin
                carry <= c_p0;
                s_dig <= s_p0;
            end
            if (last) begin
`ifdef SERIAL_ADDSUB_SAT_EN
                sum <= ovf_p0 ? sat_word(a_dig[DIGIT-1]) : word_p0;
`else
                sum <= word_p0;
`endif
                cout <= c_p0;
                ovf  <= ovf_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) sub_r <= sub;
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_addsub_word.sv
module tb_serial_addsub_word;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [0:0] a_dig = '0, b_dig = '0;
    logic [0:0] s_dig;
    logic       s_valid, busy, done, cout, ovf;
    logic [7:0] sum;

    logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] s_dig4;
    logic       s_valid4, busy4, done4, cout4, ovf4;
    logic [7:0] sum4;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int dc;

    res_t sb_q[$];
    logic dig_q[$];

    always #5 clk = ~clk;

    serial_addsub_word #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .cin(cin),
        .a_dig(a_dig), .b_dig(b_dig), .s_dig(s_dig), .s_valid(s_valid),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_addsub_word #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub4), .cin(cin4),
        .a_dig(a4), .b_dig(b4), .s_dig(s_dig4), .s_valid(s_valid4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wrapped arithmetic reference: full 9-bit sum of a, effective b and carry.
    function automatic res_t model(input logic s, input logic c, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] be;
        logic [8:0] f;
        res_t r;
        be = s ? ~b : b;
        f = {1'b0, a} + {1'b0, be} + {8'b0, s ^ c};
        r.sum  = f[7:0];
        r.cout = f[8];
        r.ovf  = (a[7] == be[7]) && (f[7] != a[7]);
        return r;
    endfunction

    // Called positioned at a negedge; drives nd digits, leaving the last one
    // on the inputs. At step glitch_at, start is pulsed with flipped sub/cin.
    task automatic drive_word(input logic s, input logic c, input logic [7:0] a,
                              input logic [7:0] b, input int nd, input int glitch_at);
        res_t r;
        r = model(s, c, a, b);
        for (int k = 0; k < 8; k++) dig_q.push_back(r.sum[k]);
`ifdef SERIAL_ADDSUB_SAT_EN
        if (r.ovf) r.sum = a[7] ? 8'h80 : 8'h7F;
`endif
        sb_q.push_back(r);
        start = 1'b1; sub = s; cin = c; a_dig = a[0]; b_dig = b[0];
        for (int i = 1; i < nd; i++) begin
            @(negedge clk);
            start = (i == glitch_at);
            sub   = (i == glitch_at) ? ~s : s;
            cin   = (i == glitch_at) ? ~c : c;
            a_dig = a[i];
            b_dig = b[i];
        end
    endtask

    always @(negedge clk) begin : mon
        res_t r;
        if (!reset) begin
            if (s_valid) begin
                if (dig_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL s_valid_extra observed 1 expected 0");
                end else begin
                    chk("s_dig", s_dig, dig_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL done_extra observed 1 expected 0");
                end else begin
                    r = sb_q.pop_front();
                    chk("sb_sum", sum, r.sum);
                    chk("sb_cout", cout, r.cout);
                    chk("sb_ovf", ovf, r.ovf);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp4;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_sum", sum, 8'h00);
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;

        // Test 1: 0xFF + 0x0D + cin
        @(negedge clk);
        drive_word(1'b0, 1'b1, 8'hFF, 8'h0D, 8, -1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_done_early", done, 1'b0);
        @(negedge clk);
        chk("t1_done", done, 1'b1);
        chk("t1_sum", sum, 8'h0D);
        chk("t1_cout", cout, 1'b1);
        repeat (2) @(negedge clk);
        chk("t1_idle_busy", busy, 1'b0);
        #1 dc = done_cnt;

        // Test 2: 0x05 - 0x07, then test 4 back-to-back 0x01 + 0x01
        @(negedge clk);
        drive_word(1'b1, 1'b0, 8'h05, 8'h07, 8, -1);
        @(negedge clk);
        chk("t2_done", done, 1'b1);
        chk("t2_sum", sum, 8'hFE);
        chk("t2_cout", cout, 1'b0);
        drive_word(1'b0, 1'b0, 8'h01, 8'h01, 8, -1);
        chk("t4_busy", busy, 1'b1);
        chk("t4_hold", sum, 8'hFE);
        chk("t4_done_early", done, 1'b0);
        @(negedge clk);
        chk("t4_done", done, 1'b1);
        chk("t4_sum", sum, 8'h02);
        repeat (3) @(negedge clk);
        #1 chk("t4_pulses", done_cnt, dc + 2);

        // Test 6: start pulsed mid-word with flipped sub/cin
        dc = done_cnt;
        @(negedge clk);
        drive_word(1'b1, 1'b1, 8'h40, 8'h10, 8, 3);
        @(negedge clk);
        chk("t6_done", done, 1'b1);
        chk("t6_sum", sum, 8'h2F);
        chk("t6_cout", cout, 1'b1);
        repeat (4) @(negedge clk);
        #1 chk("t6_pulses", done_cnt, dc + 1);

        // Test 3: DIGIT=4, 0x3C + 0x45
`ifdef SERIAL_ADDSUB_SAT_EN
        exp4 = 8'h7F;
`else
        exp4 = 8'h81;
`endif
        @(negedge clk);
        start4 = 1'b1; sub4 = 1'b0; cin4 = 1'b0; a4 = 4'hC; b4 = 4'h5;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'h3; b4 = 4'h4;
        chk("t3_dig0", s_dig4, 4'h1);
        chk("t3_vld0", s_valid4, 1'b1);
        chk("t3_done_early", done4, 1'b0);
        @(negedge clk);
        chk("t3_dig1", s_dig4, 4'h8);
        chk("t3_done", done4, 1'b1);
        chk("t3_sum", sum4, exp4);
        chk("t3_cout", cout4, 1'b0);
        chk("t3_ovf", ovf4, 1'b1);
        @(negedge clk);
        chk("t3_done_once", done4, 1'b0);

        // Test 5: reset in the middle of a word
        @(negedge clk);
        drive_word(1'b0, 1'b0, 8'h33, 8'h11, 5, -1);
        #2 reset = 1'b1;
        #1;
        chk("t5_s_dig", s_dig, 1'b0);
        chk("t5_s_valid", s_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_sum", sum, 8'h00);
        chk("t5_cout", cout, 1'b0);
        chk("t5_ovf", ovf, 1'b0);
        sb_q.delete();
        dig_q.delete();
        @(negedge clk);
        reset = 1'b0;
        dc = done_cnt;
        repeat (12) @(negedge clk);
        #1;
        chk("t5_no_done", done_cnt, dc);
        chk("t5_sum_after", sum, 8'h00);
        chk("t5_busy_after", busy, 1'b0);

        // Positive overflow after reset recovery
        @(negedge clk);
        drive_word(1'b0, 1'b0, 8'h7F, 8'h01, 8, -1);
        @(negedge clk);
        chk("t7_done", done, 1'b1);
        chk("t7_ovf", ovf, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        chk("dig_drained", dig_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
